// File: rtl/number_scan_display.sv
// rtl/number_scan_display.sv - sequential multi-digit seven-segment driver reusing one number_display
// Optional feature macro: NUMBER_SCAN_ZERO_EN (input 0 commits the digit-0 pattern in slot 0)

module number_display #(
   parameter int NUMBER_WIDTH = 16
) (
   input  logic [NUMBER_WIDTH-1:0] i_number,
   output logic [6:0]              o_segments,
   output logic [NUMBER_WIDTH-1:0] o_remaining
);

   logic [NUMBER_WIDTH-1:0] w_digit;

   // A zero input is an empty digit, which is what blanks the leading positions.
   always_comb begin
      w_digit     = i_number % NUMBER_WIDTH'(10);
      o_remaining = i_number / NUMBER_WIDTH'(10);
      o_segments  = 7'h00;
      if (i_number != '0) begin
         case (w_digit)
            NUMBER_WIDTH'(0): o_segments = 7'h3F;
            NUMBER_WIDTH'(1): o_segments = 7'h0C;
            NUMBER_WIDTH'(2): o_segments = 7'h76;
            NUMBER_WIDTH'(3): o_segments = 7'h5E;
            NUMBER_WIDTH'(4): o_segments = 7'h4D;
            NUMBER_WIDTH'(5): o_segments = 7'h5B;
            NUMBER_WIDTH'(6): o_segments = 7'h7B;
            NUMBER_WIDTH'(7): o_segments = 7'h0E;
            NUMBER_WIDTH'(8): o_segments = 7'h7F;
            NUMBER_WIDTH'(9): o_segments = 7'h5F;
            default:          o_segments = 7'h00;
         endcase
      end
   end

endmodule

module number_scan_display #(
   parameter int NUMBER_WIDTH = 16,
   parameter int DIGITS       = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUMBER_WIDTH-1:0] number_in,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [7*DIGITS-1:0]     segments,
   output logic                    overflow
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [NUMBER_WIDTH-1:0] r_cur;
   logic [IDX_W-1:0]        r_idx;
   logic [7*DIGITS-1:0]     r_shadow;
   logic [7*DIGITS-1:0]     r_segments;
   logic                    r_overflow;

   logic [6:0]              w_seg;
   logic [6:0]              w_seg_cap;
   logic [NUMBER_WIDTH-1:0] w_remaining;
   logic [7*DIGITS-1:0]     w_shadow_next;
   logic                    w_last;

   number_display #(
      .NUMBER_WIDTH (NUMBER_WIDTH)
   ) u_digit (
      .i_number    (r_cur),
      .o_segments  (w_seg),
      .o_remaining (w_remaining)
   );

`ifdef NUMBER_SCAN_ZERO_EN
   // cur is only zero at slot 0 when the latched value itself was zero.
   assign w_seg_cap = ((r_idx == '0) && (r_cur == '0)) ? 7'h3F : w_seg;
`else
   assign w_seg_cap = w_seg;
`endif

   assign w_last = (r_idx == IDX_W'(DIGITS - 1));

   // Shadow with the current slot already replaced, so the commit sees the final digit too.
   always_comb begin
      w_shadow_next = r_shadow;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_shadow_next[7*i +: 7] = w_seg_cap;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SCAN;
         S_SCAN:  if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur      <= '0;
         r_idx      <= '0;
         r_shadow   <= '0;
         r_segments <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur <= number_in;
                  r_idx <= '0;
               end
            end
            S_SCAN: begin
               r_shadow <= w_shadow_next;
               r_cur    <= w_remaining;
               r_idx    <= r_idx + IDX_W'(1);
               if (w_last) begin
                  r_segments <= w_shadow_next;
                  r_overflow <= (w_remaining != '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state == S_SCAN);
   assign done     = (r_state == S_DONE);
   assign segments = r_segments;
   assign overflow = r_overflow;

endmodule
